vsim_receive_fifo: RTL and testbench
====================================

# vsim_receive_fifo

Simulation-side host-to-hardware message receiver. Polls the host through a DPI import, assembles 32-bit host beats into WIDTH-bit words and buffers them in a DEPTH-entry FIFO. Words are delivered to the design on an enq/RDY/last pipe. It is the multi-channel, wide-word, buffered successor to the single-beat receiver. Polling is decoupled from downstream backpressure, so the host is never stalled by a one-cycle RDY drop.

## Interface
- WIDTH, 64: delivered word width; multiple of 32, range 32..512.
- DEPTH, 4: FIFO entries; power of two, range 2..64.
- CHANNEL, 0: host channel number passed to the DPI poll; 0..255.
- CLK  in  1  clock.
- nRST  in  1  reset; synchronous, active-high.
- enq__RDY  in  1  downstream can accept a word this cycle.
- enq__ENA  out  1  word transferred this cycle.
- enq_v  out  WIDTH  word data.
- enq_last  out  1  final word of the message.
- DPI import dpi_msgReceive_poll(input int channel) returns 64-bit beat:
  - bit 33: last.
  - bit 32: valid.
  - bits 31:0: data.

## Operation
- BEATS = WIDTH/32. Beat counter width is clog2(BEATS), minimum 1.
- Poll condition: not in reset and FIFO count < DEPTH.
  - The poll is called at posedge CLK only when the condition holds, using the registered count.
  - A pop in the same cycle does not enable a poll when full.
- A beat with valid=0 is discarded; no state change.
- A valid beat writes data into assembler slot beat_idx (first beat lands in bits 31:0, little-endian) and increments beat_idx.
- Word completion: beat_idx == BEATS-1, or last=1 (early last).
  - On completion the word plus last flag is pushed and beat_idx returns to 0.
  - Slots not written since the previous completion are zero; the assembler clears on every push.
- Count bookkeeping: a completion can only occur while polling, so count < DEPTH and the push is always accepted.
- Output is show-ahead: enq_v/enq_last = FIFO head, zero when empty.
- enq__ENA = !empty && enq__RDY (combinational). A pop occurs exactly when enq__ENA=1.
- Simultaneous push and pop: count unchanged, both take effect.
- Reset values:
  - count 0, beat_idx 0, assembler 0.
  - enq__ENA 0, enq_v 0, enq_last 0.
  - No poll in reset cycles.
- Reset mid-word drops the partial word; reset with a non-empty FIFO drops all queued words. The host is not informed.

## Timing
- Completing beat polled at edge N → word at FIFO head and enq__ENA possible in cycle N+1.
- Minimum latency: BEATS edges from first beat to availability.
- Throughput: one word per BEATS cycles when the host supplies a valid beat every cycle.
- FIFO at DEPTH: polling pauses from the cycle after the push that filled it, and resumes the cycle after the first pop.
- enq__RDY → enq__ENA is combinational, 0 cycles. No combinational path from the DPI to any output.

## Configuration
- VSIM_RECEIVE_TRACE_EN defined: every transfer (enq__ENA=1) issues $display with time, CHANNEL, enq_last and enq_v in hex. Every early-last completion additionally reports beat_idx.
- VSIM_RECEIVE_TRACE_EN undefined: no display statements. Functional behaviour is identical.

## Structure
- Package vsim_pkg holds:
  - VSIM_BEAT_W=32, VSIM_VALID_BIT=32, VSIM_LAST_BIT=33.
  - Typedef vsim_beat_t (packed last, valid, data[31:0]).
  - The DPI import declaration.
- Sub-module vsim_fifo: synchronous show-ahead FIFO, parameters WIDTH+1 and DEPTH. It exposes count, full, empty and head and is reusable by the matching send block.
- The top module holds the poll gate, beat assembler and output logic.

## Test plan
- WIDTH=64, DEPTH=4, RDY=1, host sends beats 0x11111111 then 0x22222222 with last=1 → one transfer, enq_v=0x22222222_11111111, enq_last=1, one cycle after the second beat.
- WIDTH=96, host sends a single beat 0xAAAA0001 with last=1 → enq_v=0x0..0_AAAA0001, enq_last=1. With trace enabled, early-last reported with beat_idx 0.
- DEPTH=4, RDY=0, host offers 6 two-beat words → exactly 4 pushed, polls stop, words 5 and 6 remain unconsumed at host. Raising RDY delivers all 6 in order.
- RDY toggling 1/0 each cycle with continuous host supply → no word lost or duplicated over 100 words, compared in order against a host-side scoreboard.
- Assert nRST for 1 cycle after the first of two beats → partial word dropped, outputs 0. The next two beats form a fresh word.
- Host returns valid=0 for 10 cycles between beats of one word → assembled word unchanged, delivered once.

Source files
------------

// File: rtl/vsim_pkg.sv
// Shared beat format and host poll hook for the vsim message blocks.
// An in-simulator host queue answers the poll.
package vsim_pkg;

  localparam int VSIM_BEAT_W    = 32;
  localparam int VSIM_VALID_BIT = 32;
  localparam int VSIM_LAST_BIT  = 33;

  typedef struct packed {
    logic                   last;
    logic                   valid;
    logic [VSIM_BEAT_W-1:0] data;
  } vsim_beat_t;

  function automatic int vsim_clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One beat queue per host channel; an empty queue answers with valid=0.
  logic [63:0] vsim_host_q [256][$];

  function automatic longint dpi_msgReceive_poll(input int channel);
    if (channel < 0 || channel > 255) return 64'd0;
    if (vsim_host_q[channel[7:0]].size() == 0) return 64'd0;
    return longint'(vsim_host_q[channel[7:0]].pop_front());
  endfunction

endpackage

// File: rtl/vsim_fifo.sv
// Synchronous show-ahead FIFO: head is valid whenever !empty and reads zero when empty.
module vsim_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rptr];

    always_ff @(posedge CLK) begin
        if (nRST) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/vsim_receive_fifo.sv
// Host-to-hardware receiver: polls 32-bit beats, assembles WIDTH-bit words, buffers DEPTH words.
// Define VSIM_RECEIVE_TRACE_EN to print every transfer and every early-last completion.
module vsim_receive_fifo
    import vsim_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int DEPTH   = 4,
    parameter int CHANNEL = 0
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             enq__RDY,
    output logic             enq__ENA,
    output logic [WIDTH-1:0] enq_v,
    output logic             enq_last
);

    localparam int BEATS = WIDTH / VSIM_BEAT_W;
    localparam int IDX_W = vsim_clog2_min1(BEATS);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic             cmp_v;
        logic             cmp_last;
        logic [WIDTH-1:0] cmp_word;
        logic [IDX_W-1:0] idx;
        logic [WIDTH-1:0] slots;
    } asm_t;

    asm_t             st;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] total;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic [WIDTH:0]   fifo_head;
    logic             poll_en;

    // The beat only exists inside the poll edge, so a completed word is held one cycle in
    // cmp_word and counted as occupancy; it is presented directly when the FIFO is empty.
    assign total   = fifo_count + CNT_W'(st.cmp_v);
    assign poll_en = !fifo_full && (total < CNT_W'(DEPTH));

    function automatic asm_t poll_step(input asm_t cur);
        asm_t        nxt;
        logic [63:0] raw;
        vsim_beat_t  beat;
        nxt       = cur;
        nxt.cmp_v = 1'b0;
        raw       = 64'(dpi_msgReceive_poll(CHANNEL));
        beat      = raw[VSIM_LAST_BIT:0];
        if (raw[VSIM_VALID_BIT]) begin
            nxt.slots[int'(cur.idx) * VSIM_BEAT_W +: VSIM_BEAT_W] = beat.data;
            if (int'(cur.idx) == BEATS - 1 || beat.last) begin
`ifdef VSIM_RECEIVE_TRACE_EN
                if (int'(cur.idx) != BEATS - 1)
                    $display("%0t vsim_receive ch%0d early last at beat_idx %0d",
                             $time, CHANNEL, cur.idx);
`endif
                nxt.cmp_v    = 1'b1;
                nxt.cmp_last = beat.last;
                nxt.cmp_word = nxt.slots;
                nxt.slots    = '0;
                nxt.idx      = '0;
            end else begin
                nxt.idx = cur.idx + 1'b1;
            end
        end
        return nxt;
    endfunction

    always_ff @(posedge CLK) begin
        if (nRST)
            st <= '0;
        else if (poll_en)
            st <= poll_step(st);
        else
            st.cmp_v <= 1'b0;
    end

    assign enq__ENA  = (!fifo_empty || st.cmp_v) && enq__RDY;
    assign fifo_pop  = enq__ENA && !fifo_empty;
    assign fifo_push = st.cmp_v && !(enq__ENA && fifo_empty);

    vsim_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .nRST      (nRST),
        .push      (fifo_push),
        .push_data ({st.cmp_last, st.cmp_word}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        {enq_last, enq_v} = '0;
        if (!fifo_empty)
            {enq_last, enq_v} = fifo_head;
        else if (st.cmp_v)
            {enq_last, enq_v} = {st.cmp_last, st.cmp_word};
    end

`ifdef VSIM_RECEIVE_TRACE_EN
    always_ff @(posedge CLK) begin
        if (!nRST && enq__ENA)
            $display("%0t vsim_receive ch%0d last=%0b data=%h", $time, CHANNEL, enq_last, enq_v);
    end
`endif

endmodule

// File: tb/tb_vsim_receive_fifo.sv
// Scoreboard bench for vsim_receive_fifo: a 64-bit/4-deep instance on channel 0 and a 96-bit instance on channel 1.
module tb_vsim_receive_fifo;
    import vsim_pkg::*;

    logic        CLK  = 1'b0;
    logic        nRST = 1'b1;
    logic        rdy0 = 1'b1;
    logic        rdy1 = 1'b1;
    logic        ena0, ena1, last0, last1;
    logic [63:0] v0;
    logic [95:0] v1;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int xfer_cyc0 = -1;
    int t0;
    logic [127:0] exp0[$];
    logic [127:0] exp1[$];

    vsim_receive_fifo #(.WIDTH(64), .DEPTH(4), .CHANNEL(0)) u_dut0 (
        .CLK(CLK), .nRST(nRST), .enq__RDY(rdy0),
        .enq__ENA(ena0), .enq_v(v0), .enq_last(last0)
    );

    vsim_receive_fifo #(.WIDTH(96), .DEPTH(2), .CHANNEL(1)) u_dut1 (
        .CLK(CLK), .nRST(nRST), .enq__RDY(rdy1),
        .enq__ENA(ena1), .enq_v(v1), .enq_last(last1)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [63:0] hb(input logic [31:0] d, input logic l);
        return {30'b0, l, 1'b1, d};
    endfunction

    task automatic host0(input logic [31:0] d, input logic l);
        vsim_host_q[0].push_back(hb(d, l));
    endtask

    task automatic host1(input logic [31:0] d, input logic l);
        vsim_host_q[1].push_back(hb(d, l));
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain(input string name, input int bound);
        int n = 0;
        while ((exp0.size() != 0 || exp1.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        tests++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            fails++;
            $display("FAIL %s: %0d/%0d words still expected after %0d cycles",
                     name, exp0.size(), exp1.size(), bound);
        end
        repeat (3) tick();
    endtask

    // Monitors: every transfer pops and compares the oldest expected word.
    always @(negedge CLK) begin
        if (ena0 === 1'b1) begin
            xfer_cyc0 = cyc;
            if (exp0.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL dut0 unexpected transfer: got %h want none", {last0, v0});
            end else begin
                check("dut0 word", {63'b0, last0, v0}, exp0.pop_front());
            end
        end
    end

    always @(negedge CLK) begin
        if (ena1 === 1'b1) begin
            if (exp1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL dut1 unexpected transfer: got %h want none", {last1, v1});
            end else begin
                check("dut1 word", {31'b0, last1, v1}, exp1.pop_front());
            end
        end
    end

    initial begin
        repeat (3) tick();
        check("reset ena0", ena0, 0);
        check("reset v0", v0, 0);
        check("reset last0", last0, 0);
        check("reset ena1", ena1, 0);
        check("reset v1", v1, 0);
        check("reset last1", last1, 0);
        nRST = 1'b0;
        tick();

        // Two beats, second with last: one word the cycle after the second poll
        t0 = cyc;
        host0(32'h11111111, 1'b0);
        host0(32'h22222222, 1'b1);
        exp0.push_back({63'b0, 1'b1, 64'h22222222_11111111});
        drain("basic word", 50);
        check("basic latency", xfer_cyc0, t0 + 2);

        host0(32'h0000000A, 1'b0);
        host0(32'h0000000B, 1'b0);
        exp0.push_back({63'b0, 1'b0, 64'h0000000B_0000000A});
        drain("full word no last", 50);

        // Backpressure: only DEPTH words are polled, the rest stay at the host
        rdy0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            host0(32'h50000000 + 32'(2 * i), 1'b0);
            host0(32'h50000000 + 32'(2 * i + 1), i == 5);
            exp0.push_back({63'b0, i == 5, 32'h50000000 + 32'(2 * i + 1), 32'h50000000 + 32'(2 * i)});
        end
        repeat (30) tick();
        check("bp host beats left", vsim_host_q[0].size(), 4);
        check("bp ena0", ena0, 0);
        check("bp head", {last0, v0}, {1'b0, 64'h50000001_50000000});
        rdy0 = 1'b1;
        drain("bp release", 100);

        // RDY toggling with continuous supply
        for (int i = 0; i < 100; i++) begin
            host0(32'hA0000000 + 32'(i), 1'b0);
            host0(32'hB0000000 + 32'(i), (i % 3) == 2);
            exp0.push_back({63'b0, (i % 3) == 2, 32'hB0000000 + 32'(i), 32'hA0000000 + 32'(i)});
        end
        for (int n = 0; n < 3000 && exp0.size() != 0; n++) begin
            tick();
            rdy0 = ~rdy0;
        end
        rdy0 = 1'b1;
        drain("toggle rdy", 10);

        // Reset after first beat drops the partial word
        host0(32'hDEAD0001, 1'b0);
        tick();
        nRST = 1'b1;
        tick();
        nRST = 1'b0;
        check("midreset ena0", ena0, 0);
        check("midreset v0", v0, 0);
        check("midreset last0", last0, 0);
        host0(32'h0000CAFE, 1'b0);
        host0(32'h0000BEEF, 1'b1);
        exp0.push_back({63'b0, 1'b1, 64'h0000BEEF_0000CAFE});
        drain("after reset", 50);

        // Invalid beats between beats of one word (including a last bit with valid=0)
        host0(32'h12345678, 1'b0);
        for (int i = 0; i < 10; i++)
            vsim_host_q[0].push_back((i == 4) ? 64'h2_DEADBEEF : 64'h0);
        host0(32'h9ABCDEF0, 1'b1);
        exp0.push_back({63'b0, 1'b1, 64'h9ABCDEF0_12345678});
        drain("invalid gap", 50);

        // 96-bit instance: early last after one beat, full word, then early last after two
        host1(32'hAAAA0001, 1'b1);
        exp1.push_back({31'b0, 1'b1, 96'h00000000_00000000_AAAA0001});
        host1(32'h00000001, 1'b0);
        host1(32'h00000002, 1'b0);
        host1(32'h00000003, 1'b0);
        exp1.push_back({31'b0, 1'b0, 96'h00000003_00000002_00000001});
        host1(32'h00000005, 1'b0);
        host1(32'h00000006, 1'b1);
        exp1.push_back({31'b0, 1'b1, 96'h00000000_00000006_00000005});
        drain("wide words", 50);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
